// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-entry output buffer and error pulses.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_in,
  input  logic              ready,
  output logic [BITS_N-1:0] data_rx,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_N + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(BITS_N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t            r_state, w_next;
  logic              r_sync1, r_sync2;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [BITS_N-1:0] r_shift, r_data;
  logic              r_valid, r_ferr, r_ovr;
  logic              w_rx, w_tick, w_half, w_clr, w_shift, w_stop_smp, w_good;

  assign w_rx   = r_sync2;
  assign w_tick = r_cnt == LAST;
  assign w_half = r_cnt == HALF;

`ifdef UART_RX_PARITY_EN
  logic r_par, r_perr, w_par_smp, w_par_bad;
  assign w_par_bad  = ^{r_shift, r_par};
  assign parity_err = r_perr;
`else
  logic w_par_bad;
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_shift    = 1'b0;
    w_stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_smp  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_clr  = 1'b1;
        w_next = w_rx ? S_IDLE : S_START;
      end
      S_START: if (w_half) begin
        w_clr  = 1'b1;
        w_next = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: if (w_tick) begin
        w_clr   = 1'b1;
        w_shift = 1'b1;
`ifdef UART_RX_PARITY_EN
        w_next  = (r_bit == BLAST) ? S_PARITY : S_DATA;
`else
        w_next  = (r_bit == BLAST) ? S_STOP : S_DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_tick) begin
        w_clr     = 1'b1;
        w_par_smp = 1'b1;
        w_next    = S_STOP;
      end
`endif
      S_STOP: if (w_tick) begin
        w_clr      = 1'b1;
        w_stop_smp = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A good frame is buffered unless the previous byte is still unconsumed.
  assign w_good = w_stop_smp & w_rx & ~w_par_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      r_sync1 <= uart_in;
      r_sync2 <= r_sync1;
      r_cnt   <= w_clr ? '0 : r_cnt + CW'(1);
      if (w_shift) begin
        r_shift <= {w_rx, r_shift[BITS_N-1:1]};
        r_bit   <= (r_bit == BLAST) ? '0 : r_bit + BW'(1);
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_par_smp) r_par <= w_rx;
      r_perr <= w_stop_smp & w_par_bad;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_smp & ~w_rx;
      r_ovr  <= w_good & r_valid & ~ready;
      if (w_good && (!r_valid || ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_rx   = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame vectors and corner-case sequences for uart_rx.
// Parity cases are built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int CPB = 434;

  logic       clk = 1'b0, rst = 1'b0, uart_in = 1'b1, ready = 1'b1;
  logic [7:0] data_rx;
  logic       valid, frame_err, overrun, parity_err;

  int n_checks = 0, n_err = 0;
  int n_hs = 0, n_fe = 0, n_ov = 0, n_pe = 0;
  int b_hs, b_fe, b_ov, b_pe;
  logic [7:0] q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .ready(ready),
    .data_rx(data_rx), .valid(valid), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (rst) begin
    if (valid && ready) begin
      n_hs++;
      q.push_back(data_rx);
    end
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (parity_err) n_pe++;
  end

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         hs;
    int         fe;
  } vec_t;
  vec_t tv[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic snap();
    b_hs = n_hs; b_fe = n_fe; b_ov = n_ov; b_pe = n_pe;
    q.delete();
  endtask

  task automatic chk_counts(input string nm, input int hs, input int fe, input int ov, input int pe);
    chk({nm, " handshakes"}, n_hs - b_hs, hs);
    chk({nm, " frame_err"}, n_fe - b_fe, fe);
    chk({nm, " overrun"}, n_ov - b_ov, ov);
    chk({nm, " parity_err"}, n_pe - b_pe, pe);
  endtask

  task automatic send_bit(input logic b);
    uart_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ pflip);
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    uart_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_pop(input string nm, input logic [7:0] exp);
    chk(nm, (q.size() > 0) ? int'(q.pop_front()) : -1, exp);
  endtask

  initial begin
    tv[0] = '{8'h55, 1'b1, 1, 0};
    tv[1] = '{8'h5A, 1'b0, 0, 1};
    tv[2] = '{8'h5A, 1'b1, 1, 0};
    tv[3] = '{8'h80, 1'b1, 1, 0};

    repeat (5) @(negedge clk);
    chk("reset valid", valid, 0);
    chk("reset data_rx", data_rx, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset parity_err", parity_err, 0);
    rst = 1'b1;
    idle(10);

    for (int i = 0; i < 4; i++) begin
      snap();
      send_frame(tv[i].d, tv[i].stop, 1'b0);
      idle(2 * CPB);
      chk_counts($sformatf("vec%0d", i), tv[i].hs, tv[i].fe, 0, 0);
      if (tv[i].hs > 0) chk_pop($sformatf("vec%0d data", i), tv[i].d);
    end

    snap();
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    idle(2 * CPB);
    chk_counts("b2b", 3, 0, 0, 0);
    chk_pop("b2b first", 8'hA3);
    chk_pop("b2b second", 8'hFF);
    chk_pop("b2b third", 8'h00);

    snap();
    ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    idle(CPB);
    chk("ovr valid held", valid, 1);
    chk("ovr data held", data_rx, 8'h12);
    chk_counts("ovr", 0, 0, 1, 0);
    ready = 1'b1;
    idle(10);
    chk("ovr handshakes", n_hs - b_hs, 1);
    chk_pop("ovr data", 8'h12);
    chk("ovr valid drop", valid, 0);

    snap();
    uart_in = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * CPB);
    chk_counts("glitch", 0, 0, 0, 0);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    uart_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    uart_in = 1'b1;
    @(negedge clk);
    chk("midrst valid", valid, 0);
    chk("midrst data_rx", data_rx, 0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    idle(12 * CPB);
    chk_counts("midrst", 0, 0, 0, 0);

    snap();
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(2 * CPB);
    chk_counts("after rst", 1, 0, 0, 0);
    chk_pop("after rst data", 8'hC3);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    chk_counts("bad parity", 0, 0, 0, 1);
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    chk_counts("good parity", 1, 0, 0, 0);
    chk_pop("good parity data", 8'h07);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434 (50_000_000/115_200), gives clk cycles per bit period; legal range is 4 or more.
REQ-002 Parameter BITS_N, default 8, gives data bits per frame.
REQ-003 Port clk, input, 1 bit: single clock; all state is on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port uart_in, input, 1 bit: serial line; idle high; asynchronous to clk.
REQ-006 Port data_rx, output, BITS_N bits: received byte.
REQ-007 Port valid, output, 1 bit: data_rx holds an unconsumed byte.
REQ-008 Port ready, input, 1 bit: consumer accepts data_rx.
REQ-009 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 Port overrun, output, 1 bit: one-cycle pulse when a good frame is dropped because the buffer is full.
REQ-011 Port parity_err, output, 1 bit: one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-012 uart_in SHALL pass through a 2-flop synchronizer preset to 1; all logic uses the synchronized value.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY (present only with the macro) and STOP, plus one bit counter and one clock counter.
REQ-014 IDLE to START SHALL occur on the first cycle the synchronized line is low; the clock counter clears.
REQ-015 START SHALL sample the line at count CLKS_PER_BIT/2 (integer divide): low goes to DATA with counter cleared; high is a glitch and returns to IDLE with no output pulse.
REQ-016 DATA SHALL sample every CLKS_PER_BIT cycles from the start midpoint, shifting LSB first, for exactly BITS_N samples.
REQ-017 STOP SHALL sample the line one bit period after the last data or parity sample, then go to IDLE on the next cycle so a back-to-back start bit is detected.
REQ-018 Stop sampled high with no parity error SHALL be a good frame; stop sampled low SHALL pulse frame_err for one cycle and discard the byte.
REQ-019 On a good frame with valid=0, data_rx SHALL load and valid SHALL rise on the cycle after the stop sample.
REQ-020 valid and data_rx SHALL stay stable until a cycle with valid=1 and ready=1, after which valid drops on the next edge.
REQ-021 On a good frame with valid=1 and ready=0, the new byte SHALL be dropped, overrun SHALL pulse for one cycle, and the old byte is kept.
REQ-022 If a good frame completes in the same cycle as a handshake (valid=1, ready=1), the new byte SHALL load and valid SHALL stay 1; no overrun.
REQ-023 ready SHALL have no effect on the receive FSM; reception never stalls.

Reset
REQ-024 While rst=0: FSM in IDLE, counters 0, synchronizer flops 1, data_rx 0, and valid, frame_err, overrun and parity_err all 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a fresh falling edge and produces no output for the partial frame.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, each frame SHALL carry one even-parity bit after the data bits, sampled in PARITY.
REQ-027 Under that macro, a parity mismatch SHALL pulse parity_err for one cycle on the cycle after the stop sample and discard the byte; a low stop bit still pulses frame_err.
REQ-028 Without the macro there SHALL be no PARITY state, frames are 8N1-style, and parity_err is tied to 0.

Verification (CLKS_PER_BIT=434, BITS_N=8, 50 MHz clk, ready=1 unless stated)
REQ-029 Drive frame 0x55 -> exactly one valid pulse with data_rx=0x55; no error pulses.
REQ-030 Drive 0xA3, then 0xFF back-to-back with zero idle, then 0x00 -> three valid handshakes with data_rx 0xA3, 0xFF, 0x00 in order.
REQ-031 Hold ready=0 and drive 0x12 then 0x34 -> data_rx stays 0x12 with valid=1; one overrun pulse occurs; raising ready yields 0x12 only.
REQ-032 Drive 0x5A with the stop bit low -> one frame_err pulse, valid stays 0; a following 0x5A frame is received correctly.
REQ-033 Drive a 100-cycle low glitch, and separately assert rst mid-frame at bit 4 -> no valid and no error pulses; the next 0xC3 frame is received correctly.
REQ-034 With UART_RX_PARITY_EN defined, drive 0x07 with parity bit 0 (even parity requires 1) -> one parity_err pulse, no valid; the same byte with parity 1 -> valid with data_rx=0x07.
